// File: rtl/axi4stream_burst_framer_pkg.sv
// Purpose: shared state encoding and default widths for the burst framer and its W register slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4stream_burst_framer_pkg;

  localparam int DEF_AWPORT_WIDTH = 2;
  localparam int DEF_AWLEN_WIDTH  = 16;
  localparam int DEF_AWSIZE_WIDTH = 16;
  localparam int DEF_WIDTH        = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/axi4stream_burst_framer.sv
// Purpose: turns one command (port/len/size) plus a last-less data stream into one AW and a W burst with WLAST.
// Latency: AW one cycle after command accept; W beats pass through combinationally; one idle cycle between bursts.
// Backpressure: D_READY follows M_WREADY while the burst is open; C_READY is low for the whole burst.
// Optional: define AXI4STREAM_BURST_FRAMER_STATUS_EN to add the STAT_BURSTS completed-burst counter.
module axi4stream_burst_framer
  import axi4stream_burst_framer_pkg::*;
#(
  parameter int AWPORT_WIDTH = DEF_AWPORT_WIDTH,
  parameter int AWLEN_WIDTH  = DEF_AWLEN_WIDTH,
  parameter int AWSIZE_WIDTH = DEF_AWSIZE_WIDTH,
  parameter int WIDTH        = DEF_WIDTH
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic [AWPORT_WIDTH-1:0] C_AWPORT,
  input  logic [AWLEN_WIDTH-1:0]  C_AWLEN,
  input  logic [AWSIZE_WIDTH-1:0] C_AWSIZE,
  input  logic                    C_VALID,
  output logic                    C_READY,
  input  logic                    D_VALID,
  output logic                    D_READY,
  input  logic [WIDTH-1:0]        D_DATA,
  input  logic [WIDTH/8-1:0]      D_STRB,
  output logic [AWPORT_WIDTH-1:0] M_AWPORT,
  output logic [AWLEN_WIDTH-1:0]  M_AWLEN,
  output logic [AWSIZE_WIDTH-1:0] M_AWSIZE,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  output logic [WIDTH-1:0]        M_WDATA,
  output logic [WIDTH/8-1:0]      M_WSTRB,
  output logic                    M_WLAST
`ifdef AXI4STREAM_BURST_FRAMER_STATUS_EN
  ,
  output logic [31:0]             STAT_BURSTS
`endif
);

  state_t                  state, state_nxt;
  logic [AWPORT_WIDTH-1:0] cmd_port;
  logic [AWLEN_WIDTH-1:0]  cmd_len;
  logic [AWSIZE_WIDTH-1:0] cmd_size;
  logic [AWLEN_WIDTH-1:0]  beat_cnt;
  logic                    aw_pend, aw_pend_nxt;
  logic                    w_done, w_done_nxt;
  logic                    cmd_fire, w_open, w_fire;

  // AW fields come straight from the command register; W payload is a pure pass-through.
  assign M_AWPORT  = cmd_port;
  assign M_AWLEN   = cmd_len;
  assign M_AWSIZE  = cmd_size;
  assign M_AWVALID = aw_pend;
  assign M_WDATA   = D_DATA;
  assign M_WSTRB   = D_STRB;

  // Next-state and handshake decode; leave BURST once both AW and the last W beat are done, even in the same cycle.
  always_comb begin
    state_nxt   = state;
    C_READY     = 1'b0;
    cmd_fire    = 1'b0;
    w_open      = 1'b0;
    aw_pend_nxt = aw_pend;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        C_READY  = 1'b1;
        cmd_fire = C_VALID;
        if (C_VALID) state_nxt = BURST;
      end
      BURST: begin
        w_open = !w_done;
      end
      default: state_nxt = IDLE;
    endcase
    M_WVALID = w_open && D_VALID;
    D_READY  = w_open && M_WREADY;
    M_WLAST  = M_WVALID && (beat_cnt == cmd_len);
    w_fire   = M_WVALID && M_WREADY;
    if (state == BURST) begin
      aw_pend_nxt = aw_pend && !M_AWREADY;
      w_done_nxt  = w_done || (w_fire && M_WLAST);
      if (!aw_pend_nxt && w_done_nxt) state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) state <= IDLE;
    else         state <= state_nxt;
  end

  // Command capture, AW pending flag, W completion and beat counter (counter holds on the last beat, so it never wraps).
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      cmd_port <= '0;
      cmd_len  <= '0;
      cmd_size <= '0;
      aw_pend  <= 1'b0;
      w_done   <= 1'b0;
      beat_cnt <= '0;
    end else if (cmd_fire) begin
      cmd_port <= C_AWPORT;
      cmd_len  <= C_AWLEN;
      cmd_size <= C_AWSIZE;
      aw_pend  <= 1'b1;
      w_done   <= 1'b0;
      beat_cnt <= '0;
    end else if (state == BURST) begin
      aw_pend <= aw_pend_nxt;
      w_done  <= w_done_nxt;
      if (w_fire && !M_WLAST) beat_cnt <= beat_cnt + 1'b1;
    end
  end

`ifdef AXI4STREAM_BURST_FRAMER_STATUS_EN
  logic [31:0] stat_cnt;
  assign STAT_BURSTS = stat_cnt;

  // Count completed bursts on every BURST to IDLE transition; free-running wrap.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)                                   stat_cnt <= '0;
    else if (state == BURST && state_nxt == IDLE)  stat_cnt <= stat_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_axi4stream_burst_framer.sv
// Purpose: directed self-checking bench for axi4stream_burst_framer with hand-computed expectations.
// Latency: checks are cycle-exact against the expected command/beat timeline.
// Backpressure: exercises stalled AW, toggling W ready, held command valid and mid-burst reset.
module tb_axi4stream_burst_framer;

  localparam int PW = 2;
  localparam int LW = 4;
  localparam int SW = 16;
  localparam int DW = 32;

  logic          CLK_I = 1'b0;
  logic          RSTN_I = 1'b0;
  logic [PW-1:0] C_AWPORT = '0;
  logic [LW-1:0] C_AWLEN = '0;
  logic [SW-1:0] C_AWSIZE = '0;
  logic          C_VALID = 1'b0;
  logic          C_READY;
  logic          D_VALID = 1'b0;
  logic          D_READY;
  logic [DW-1:0] D_DATA = '0;
  logic [DW/8-1:0] D_STRB = '0;
  logic [PW-1:0] M_AWPORT;
  logic [LW-1:0] M_AWLEN;
  logic [SW-1:0] M_AWSIZE;
  logic          M_AWVALID;
  logic          M_AWREADY = 1'b0;
  logic          M_WVALID;
  logic          M_WREADY = 1'b0;
  logic [DW-1:0] M_WDATA;
  logic [DW/8-1:0] M_WSTRB;
  logic          M_WLAST;
`ifdef AXI4STREAM_BURST_FRAMER_STATUS_EN
  logic [31:0]   STAT_BURSTS;
`endif

  axi4stream_burst_framer #(
    .AWPORT_WIDTH(PW), .AWLEN_WIDTH(LW), .AWSIZE_WIDTH(SW), .WIDTH(DW)
  ) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I),
    .C_AWPORT(C_AWPORT), .C_AWLEN(C_AWLEN), .C_AWSIZE(C_AWSIZE),
    .C_VALID(C_VALID), .C_READY(C_READY),
    .D_VALID(D_VALID), .D_READY(D_READY), .D_DATA(D_DATA), .D_STRB(D_STRB),
    .M_AWPORT(M_AWPORT), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA),
    .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST)
`ifdef AXI4STREAM_BURST_FRAMER_STATUS_EN
    , .STAT_BURSTS(STAT_BURSTS)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_err = 0;
  int d_fires = 0;
  logic [DW-1:0] wd_q[$];
  bit            wl_q[$];
  int            aw_q[$];

  // Mid-cycle monitor: inputs are stable here, so a handshake seen now completes at the next rising edge.
  always @(negedge CLK_I) begin
    if (RSTN_I && D_VALID && D_READY) d_fires = d_fires + 1;
    if (RSTN_I && M_WVALID && M_WREADY) begin
      wd_q.push_back(M_WDATA);
      wl_q.push_back(M_WLAST);
    end
    if (RSTN_I && M_AWVALID && M_AWREADY) aw_q.push_back(int'(M_AWLEN));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the data source steps to the next word after each accepted beat.
  task automatic tick();
    @(posedge CLK_I);
    #1;
    D_DATA = 32'hA000 + d_fires;
    #1;
  endtask

  task automatic do_reset();
    RSTN_I = 1'b0;
    tick();
    tick();
    RSTN_I = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (C_READY !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n < lim), 64'd1);
  endtask

  task automatic issue(input logic [PW-1:0] port, input logic [LW-1:0] len, input logic [SW-1:0] size);
    C_AWPORT = port;
    C_AWLEN  = len;
    C_AWSIZE = size;
    C_VALID  = 1'b1;
    tick();
    C_VALID  = 1'b0;
    #1;
  endtask

  initial begin
    int na, nw;
    logic [DW-1:0] d0;

    // Reset values, with a command presented that must not be captured.
    #2;
    C_VALID = 1'b1;
    C_AWLEN = 4'd6;
    #1;
    chk("rst_awvalid", 64'(M_AWVALID), 64'd0);
    chk("rst_wvalid",  64'(M_WVALID),  64'd0);
    chk("rst_wlast",   64'(M_WLAST),   64'd0);
    chk("rst_dready",  64'(D_READY),   64'd0);
    chk("rst_cready",  64'(C_READY),   64'd1);
    tick();
    tick();
    chk("rst_nocap_awvalid", 64'(M_AWVALID), 64'd0);
    chk("rst_awlen", 64'(M_AWLEN), 64'd0);
    C_VALID = 1'b0;
    RSTN_I = 1'b1;
    tick();

    // len=3, everything ready: AW once, 4 beats, WLAST on the 4th only.
    D_VALID = 1'b1; D_STRB = 4'hF; M_AWREADY = 1'b1; M_WREADY = 1'b1;
    na = aw_q.size(); nw = wd_q.size();
    #1;
    chk("t1_cready_idle", 64'(C_READY), 64'd1);
    d0 = D_DATA;
    issue(2'd2, 4'd3, 16'd5);
    chk("t1_awvalid", 64'(M_AWVALID), 64'd1);
    chk("t1_awlen",   64'(M_AWLEN),   64'd3);
    chk("t1_awport",  64'(M_AWPORT),  64'd2);
    chk("t1_awsize",  64'(M_AWSIZE),  64'd5);
    chk("t1_wdata",   64'(M_WDATA),   64'(d0));
    for (int i = 0; i < 4; i++) begin
      chk("t1_wvalid", 64'(M_WVALID), 64'd1);
      chk("t1_cready_burst", 64'(C_READY), 64'd0);
      chk("t1_wlast", 64'(M_WLAST), 64'(i == 3));
      tick();
    end
    chk("t1_cready_back", 64'(C_READY), 64'd1);
    chk("t1_wvalid_idle", 64'(M_WVALID), 64'd0);
    chk("t1_aw_count", 64'(aw_q.size() - na), 64'd1);
    chk("t1_aw_len_seen", 64'(aw_q[na]), 64'd3);
    chk("t1_beats", 64'(wd_q.size() - nw), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", 64'(wd_q[nw+i]), 64'(d0 + i));
      chk("t1_last_seen", 64'(wl_q[nw+i]), 64'(i == 3));
    end

    // len=0 with AW stalled 5 cycles: W completes first, AW fields hold.
    M_AWREADY = 1'b0;
    na = aw_q.size(); nw = wd_q.size();
    issue(2'd1, 4'd0, 16'd2);
    chk("t2_wvalid", 64'(M_WVALID), 64'd1);
    chk("t2_wlast",  64'(M_WLAST),  64'd1);
    chk("t2_awvalid", 64'(M_AWVALID), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_awvalid_hold", 64'(M_AWVALID), 64'd1);
      chk("t2_awport_hold",  64'(M_AWPORT),  64'd1);
      chk("t2_awsize_hold",  64'(M_AWSIZE),  64'd2);
      chk("t2_wvalid_done",  64'(M_WVALID),  64'd0);
      chk("t2_dready_done",  64'(D_READY),   64'd0);
      chk("t2_cready_burst", 64'(C_READY),   64'd0);
      tick();
    end
    M_AWREADY = 1'b1;
    tick();
    chk("t2_cready_back", 64'(C_READY), 64'd1);
    chk("t2_awvalid_off", 64'(M_AWVALID), 64'd0);
    chk("t2_aw_count", 64'(aw_q.size() - na), 64'd1);
    chk("t2_beats", 64'(wd_q.size() - nw), 64'd1);
    chk("t2_last_seen", 64'(wl_q[nw]), 64'd1);

    // len=7 with M_WREADY toggling: 8 beats in order, D_READY mirrors M_WREADY.
    D_STRB = 4'h5;
    na = aw_q.size(); nw = wd_q.size();
    d0 = D_DATA;
    issue(2'd0, 4'd7, 16'd3);
    chk("t3_wstrb", 64'(M_WSTRB), 64'h5);
    for (int i = 1; i <= 15; i++) begin
      M_WREADY = (i % 2 == 1);
      #1;
      chk("t3_dready", 64'(D_READY), 64'(i % 2 == 1));
      tick();
    end
    chk("t3_cready_back", 64'(C_READY), 64'd1);
    chk("t3_beats", 64'(wd_q.size() - nw), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_data", 64'(wd_q[nw+i]), 64'(d0 + i));
      chk("t3_last_seen", 64'(wl_q[nw+i]), 64'(i == 7));
    end
    chk("t3_aw_len_seen", 64'(aw_q[na]), 64'd7);
    M_WREADY = 1'b1;
    D_STRB = 4'hF;

    // Reset during beat 2 of a len=5 burst, then a clean len=1 burst.
    M_AWREADY = 1'b0;
    issue(2'd3, 4'd5, 16'd1);
    tick();
    chk("t4_awvalid_pre", 64'(M_AWVALID), 64'd1);
    chk("t4_wvalid_pre",  64'(M_WVALID),  64'd1);
    RSTN_I = 1'b0;
    #1;
    chk("t4_awvalid_rst", 64'(M_AWVALID), 64'd0);
    chk("t4_wvalid_rst",  64'(M_WVALID),  64'd0);
    chk("t4_awlen_rst",   64'(M_AWLEN),   64'd0);
    tick();
    RSTN_I = 1'b1;
    tick();
    chk("t4_cready_rel",  64'(C_READY),   64'd1);
    chk("t4_awvalid_rel", 64'(M_AWVALID), 64'd0);
    chk("t4_wvalid_rel",  64'(M_WVALID),  64'd0);
    M_AWREADY = 1'b1;
    na = aw_q.size(); nw = wd_q.size();
    issue(2'd1, 4'd1, 16'd4);
    wait_idle(20);
    tick(); tick(); tick();
    chk("t4_aw_count", 64'(aw_q.size() - na), 64'd1);
    chk("t4_aw_len_seen", 64'(aw_q[na]), 64'd1);
    chk("t4_beats", 64'(wd_q.size() - nw), 64'd2);
    chk("t4_last_seen", 64'(wl_q[nw+1]), 64'd1);

    // C_VALID held through a len=1 burst: second command (len=2) only taken in IDLE.
    do_reset();
    na = aw_q.size(); nw = wd_q.size();
    C_AWPORT = 2'd3; C_AWLEN = 4'd1; C_AWSIZE = 16'd6; C_VALID = 1'b1;
    tick();
    C_AWPORT = 2'd0; C_AWLEN = 4'd2; C_AWSIZE = 16'd7;
    #1;
    chk("t5_cready_b1", 64'(C_READY), 64'd0);
    chk("t5_awlen_b1",  64'(M_AWLEN), 64'd1);
    chk("t5_awport_b1", 64'(M_AWPORT), 64'd3);
    tick();
    chk("t5_cready_b2", 64'(C_READY), 64'd0);
    chk("t5_awlen_b2",  64'(M_AWLEN), 64'd1);
    chk("t5_wlast_b2",  64'(M_WLAST), 64'd1);
    tick();
    chk("t5_cready_idle", 64'(C_READY), 64'd1);
    tick();
    C_VALID = 1'b0;
    #1;
    chk("t5_awvalid2", 64'(M_AWVALID), 64'd1);
    chk("t5_awlen2",   64'(M_AWLEN),   64'd2);
    wait_idle(20);
    chk("t5_aw_count", 64'(aw_q.size() - na), 64'd2);
    chk("t5_aw_first", 64'(aw_q[na]), 64'd1);
    chk("t5_aw_second", 64'(aw_q[na+1]), 64'd2);
    chk("t5_beats", 64'(wd_q.size() - nw), 64'd5);
`ifdef AXI4STREAM_BURST_FRAMER_STATUS_EN
    chk("t5_stat_bursts", 64'(STAT_BURSTS), 64'd2);
`endif

    // Maximum length (4-bit field, 15): 16 beats, counter must not wrap.
    nw = wd_q.size();
    issue(2'd2, 4'd15, 16'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t6_wlast", 64'(M_WLAST), 64'(i == 15));
      tick();
    end
    chk("t6_cready_back", 64'(C_READY), 64'd1);
    tick(); tick();
    chk("t6_beats", 64'(wd_q.size() - nw), 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4stream_burst_framer.md
AXI4STREAM_BURST_FRAMER -- requirements
Module: axi4stream_burst_framer

Interface
REQ-001 SHALL have parameter AWPORT_WIDTH, default 2, width of the port-select field.
REQ-002 SHALL have parameter AWLEN_WIDTH, default 16, width of the burst length field (AXI encoding, beats-1).
REQ-003 SHALL have parameter AWSIZE_WIDTH, default 16, width of the size field.
REQ-004 SHALL have parameter WIDTH, default 256, data width in bits; strobe width WIDTH/8.
REQ-005 SHALL have ports: CLK_I in 1 clock; RSTN_I in 1 reset, asynchronous, active-low; one clock, all logic on rising CLK_I.
REQ-006 SHALL have command ports: C_AWPORT in AWPORT_WIDTH; C_AWLEN in AWLEN_WIDTH; C_AWSIZE in AWSIZE_WIDTH; C_VALID in 1; C_READY out 1.
REQ-007 SHALL have data ports: D_VALID in 1; D_READY out 1; D_DATA in WIDTH; D_STRB in WIDTH/8 (no last input).
REQ-008 SHALL have master AW ports: M_AWPORT, M_AWLEN, M_AWSIZE out (widths as above); M_AWVALID out 1; M_AWREADY in 1.
REQ-009 SHALL have master W ports: M_WVALID out 1; M_WREADY in 1; M_WDATA out WIDTH; M_WSTRB out WIDTH/8; M_WLAST out 1 (direct fit to the downstream W register slice).

Function
REQ-010 SHALL implement states IDLE and BURST.
REQ-011 IDLE: C_READY=1; C_VALID&C_READY captures port/len/size into command register, sets aw_pend=1, clears beat counter and w_done, moves to BURST next cycle.
REQ-012 M_AWPORT/M_AWLEN/M_AWSIZE SHALL be driven from the command register; M_AWVALID=aw_pend (registered), held stable until M_AWVALID&M_AWREADY, which clears aw_pend.
REQ-013 BURST with w_done=0: M_WVALID=D_VALID, D_READY=M_WREADY, M_WDATA/M_WSTRB=D_DATA/D_STRB combinationally; otherwise M_WVALID=0, D_READY=0.
REQ-014 W beats SHALL be forwarded before, during or after the AW handshake (no ordering dependency).
REQ-015 Beat counter (AWLEN_WIDTH bits) SHALL increment on each M_WVALID&M_WREADY; M_WLAST=1 iff counter==captured len and M_WVALID=1.
REQ-016 Handshake with M_WLAST=1 SHALL set w_done; no further D beats accepted in that burst.
REQ-017 BURST→IDLE when aw_pend=0 and w_done=1, including same-cycle clearing of both; one bubble cycle before next command.
REQ-018 len=0 SHALL yield single beat with M_WLAST=1; len=2^AWLEN_WIDTH-1 SHALL yield 2^AWLEN_WIDTH beats, counter never wraps.
REQ-019 C_READY=0 throughout BURST; C_VALID in BURST ignored.

Reset
REQ-020 RSTN_I low SHALL immediately force IDLE, aw_pend=0, w_done=0, counter=0, command register=0.
REQ-021 Output values in reset: M_AWVALID=0, M_WVALID=0, M_WLAST=0, D_READY=0, M_AW* fields=0; C_READY=1 but no capture while RSTN_I low.
REQ-022 Reset mid-burst SHALL abandon the burst; no residual beats or AW after release.

Configuration
REQ-023 Macro AXI4STREAM_BURST_FRAMER_STATUS_EN defined: output STAT_BURSTS (32 bits) counts completed bursts (BURST→IDLE transitions), wraps at 2^32, reset 0.
REQ-024 Macro undefined: STAT_BURSTS port and counter absent; all other behaviour identical.

Structure
REQ-025 Shared package SHALL hold the state enum (IDLE, BURST) and default width constants reused by the register slice.
REQ-026 Single flat module; no sub-module.

Verification
REQ-027 Cmd len=3, D_VALID=1, M_AWREADY=M_WREADY=1 -> one AW with AWLEN=3, 4 beats, M_WLAST on beat 4 only, C_READY high again 1 cycle later.
REQ-028 Cmd len=0, M_AWREADY held 0 for 5 cycles -> single beat with M_WLAST completes first, M_AWVALID stays 1 with stable fields, IDLE after AW handshake.
REQ-029 len=7, M_WREADY toggling 1/0 each cycle -> 8 beats, data order preserved, D_READY mirrors M_WREADY, no beat duplicated or lost.
REQ-030 RSTN_I low during beat 2 of len=5 burst -> M_AWVALID/M_WVALID 0 same cycle, after release C_READY=1, next cmd len=1 yields exactly 2 beats.
REQ-031 C_VALID held during BURST with second cmd len=2 -> second cmd captured only in IDLE, AW issued after first burst's last beat; with STATUS_EN, STAT_BURSTS=2.
